// File: rtl/result_drain_if.sv
// Writeback stream from result_drain toward the result memory.
//   wb_data   : result word
//   wb_addr   : {col, row} tag, column in the MSBs
//   wb_valid  : beat present
//   wb_ready  : downstream accepts on wb_valid && wb_ready at a rising edge
//   wb_parity : even parity over {wb_addr, wb_data} (RESULT_DRAIN_PARITY_EN only)
// master = drain side, slave = result memory side.
interface result_drain_if #(
  parameter int DW = 32,
  parameter int AW = 6
);
  logic [DW-1:0] wb_data;
  logic [AW-1:0] wb_addr;
  logic          wb_valid;
  logic          wb_ready;
`ifdef RESULT_DRAIN_PARITY_EN
  logic          wb_parity;

  modport master (output wb_data, wb_addr, wb_valid, wb_parity, input wb_ready);
  modport slave  (input wb_data, wb_addr, wb_valid, wb_parity, output wb_ready);
`else
  modport master (output wb_data, wb_addr, wb_valid, input wb_ready);
  modport slave  (input wb_data, wb_addr, wb_valid, output wb_ready);
`endif
endinterface

// File: rtl/result_drain.sv
// result_drain: round-robin drain of the COLS per-column output buffers of the
// systolic array. Each grant pops one result, tags it with {col, row} and
// registers it onto a single valid/ready writeback stream. done pulses once
// all COLS*ROWS results of the tile have been accepted downstream.
//
// Ports:
//   clk, rstn    : clock, asynchronous active-low reset
//   start        : arm a new tile (IDLE only)
//   col_r        : head result of each column buffer
//   col_rvalid   : column buffer holds an unread result
//   col_read     : one-hot pop strobe (combinational)
//   wb           : writeback stream (result_drain_if.master)
//   busy         : high while draining
//   done         : one-cycle pulse after the last acceptance
//
// Optional feature: define RESULT_DRAIN_PARITY_EN to add wb.wb_parity.

// Per-column row counter; saturates at ROWS so a buffer that over-delivers
// is masked from arbitration for the rest of the tile.
module result_drain_col #(
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          pop,
  input  logic          rvalid,
  output logic [RW-1:0] row_idx,
  output logic          eligible
);
  logic [RW:0] row_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                    row_cnt <= '0;
    else if (clr)                 row_cnt <= '0;
    else if (pop && !row_cnt[RW]) row_cnt <= row_cnt + 1'b1;
  end

  // ROWS is a power of two, so the MSB alone marks "all rows delivered".
  assign eligible = rvalid && !row_cnt[RW];
  assign row_idx  = row_cnt[RW-1:0];
endmodule

module result_drain #(
  parameter int COLS     = 8,
  parameter int ROWS     = 8,
  parameter int OUTWIDTH = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [OUTWIDTH-1:0] col_r [COLS],
  input  logic [COLS-1:0]     col_rvalid,
  output logic [COLS-1:0]     col_read,
  result_drain_if.master      wb,
  output logic                busy,
  output logic                done
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int TW = $clog2(COLS*ROWS) + 1;
  localparam logic [TW-1:0] LAST = TW'(COLS*ROWS - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t                     state;
  logic [CW-1:0]              ptr;
  logic [TW-1:0]              total;
  logic [COLS-1:0]            eligible;
  logic [COLS-1:0][RW-1:0]    row_idx;
  logic                       clr;
  logic                       accept;
  logic                       out_free;
  logic                       gnt_found;
  logic [CW-1:0]              gnt_idx;
  logic [CW-1:0]              cand;
  logic                       grant;
  logic [CW+RW-1:0]           nxt_addr;

  assign clr      = (state == IDLE) && start;
  assign accept   = wb.wb_valid && wb.wb_ready;
  assign out_free = !wb.wb_valid || wb.wb_ready;

  result_drain_col #(.RW(RW)) u_col [COLS-1:0] (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (clr),
    .pop      (col_read),
    .rvalid   (col_rvalid),
    .row_idx  (row_idx),
    .eligible (eligible)
  );

  // First eligible column at or after ptr; index arithmetic wraps mod COLS.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < COLS; i++) begin
      cand = ptr + CW'(i);
      if (!gnt_found && eligible[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign grant    = (state == DRAIN) && out_free && gnt_found;
  assign nxt_addr = {gnt_idx, row_idx[gnt_idx]};

  always_comb begin
    col_read = '0;
    if (grant) col_read[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      ptr         <= '0;
      total       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wb.wb_valid <= 1'b0;
      wb.wb_data  <= '0;
      wb.wb_addr  <= '0;
`ifdef RESULT_DRAIN_PARITY_EN
      wb.wb_parity <= 1'b0;
`endif
    end else begin
      // Output register: reload on grant (covers back-to-back), drop on a
      // bare acceptance, otherwise hold (back-pressure).
      if (grant) begin
        wb.wb_valid <= 1'b1;
        wb.wb_data  <= col_r[gnt_idx];
        wb.wb_addr  <= nxt_addr;
`ifdef RESULT_DRAIN_PARITY_EN
        wb.wb_parity <= ^{nxt_addr, col_r[gnt_idx]};
`endif
        ptr <= gnt_idx + 1'b1;
      end else if (accept) begin
        wb.wb_valid <= 1'b0;
      end

      if (accept) total <= total + 1'b1;

      case (state)
        IDLE: if (start) begin
          state <= DRAIN;
          busy  <= 1'b1;
          ptr   <= '0;
          total <= '0;
        end
        DRAIN: if (accept && total == LAST) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/result_drain.md
# result_drain

Downstream consumer of the per-column output buffers in the systolic array. Round-robin arbitrates across `COLS` column buffers, pops one result per cycle through each column's read strobe, and tags each result with its (column, row) coordinate. Emits tagged results on a single valid/ready writeback stream toward the result memory. Signals completion once all `COLS*ROWS` results of a tile have been accepted downstream.

## Interface
- `COLS`, 8: number of array columns (column buffers drained); power of two, ≥2.
- `ROWS`, 8: results per column per tile; power of two, ≥2.
- `OUTWIDTH`, 32: result width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `start`  in  1  arm drain for a new tile; honoured only in IDLE.
- `col_r`  in  `[OUTWIDTH-1:0] [0:COLS-1]`  head result of each column buffer; combinational from the buffer.
- `col_rvalid`  in  `[0:COLS-1]`  column buffer holds an unread result.
- `col_read`  out  `[0:COLS-1]`  one-hot pop strobe; buffer advances on the same edge.
- `wb_data`  out  OUTWIDTH  result.
- `wb_addr`  out  `$clog2(COLS)+$clog2(ROWS)`  `{col, row}` tag; col in the MSBs.
- `wb_valid`  out  1  `wb_data`/`wb_addr` valid.
- `wb_ready`  in  1  downstream accepts when `wb_valid && wb_ready` at a rising edge.
- `busy`  out  1  high in DRAIN.
- `done`  out  1  one-cycle pulse when the tile's last result is accepted.

## Operation
- FSM states:
  - IDLE:
    - `start` → DRAIN.
    - On entry to DRAIN: clear all per-column row counters, total counter and RR pointer (pointer = 0).
  - DRAIN:
    - Arbitrates and emits results.
    - Acceptance of beat number `COLS*ROWS-1` (last) → DONE.
  - DONE:
    - Asserts `done` for exactly one cycle.
    - → IDLE unconditionally.
- Eligibility: column c is eligible iff `col_rvalid[c]` and `row_cnt[c] < ROWS`. A completed column is masked even if its `col_rvalid` stays high.
- Grant:
  - In DRAIN, when the output register is free (`!wb_valid || wb_ready`), grant the first eligible column searching c = ptr, ptr+1, …, wrapping mod COLS.
  - Drive `col_read[c]=1` for that cycle only.
  - On the same edge:
    - `wb_data <= col_r[c]`
    - `wb_addr <= {c, row_cnt[c]}`
    - `wb_valid <= 1`
    - `row_cnt[c]++`
    - `ptr <= (c+1) mod COLS`
- No eligible column, or output register full and `wb_ready=0`: `col_read` all 0, ptr unchanged.
- Output register:
  - Accepted and no new grant: `wb_valid <= 0`.
  - Accepted and new grant: reload (back-to-back, 1 result/cycle).
- Counters:
  - `row_cnt[c]` is `$clog2(ROWS)+1` bits, saturating at ROWS.
  - Total-accepted counter is `$clog2(COLS*ROWS)+1` bits, incremented on each accepted beat.
- Arithmetic: `wb_data` passes through unmodified; no width change.
- `start` in DRAIN/DONE: ignored.
- `col_rvalid` outside DRAIN: ignored, no pops.

## Timing
- Reset (async, any state): state IDLE, `col_read=0`, `wb_valid=0`, `wb_data=0`, `wb_addr=0`, `busy=0`, `done=0`, all counters 0, ptr=0.
- `col_read` is combinational from registered state plus `col_rvalid`/`wb_ready`. No combinational path from `col_r` to any output.
- Latency: pop edge → `wb_valid` high the following cycle (1 cycle).
- `busy` rises the cycle after `start` is sampled in IDLE.
- `done`: high in the cycle after the last acceptance edge; `busy` low in that same cycle.
- Back-pressure: while `wb_valid && !wb_ready`, `wb_data`/`wb_addr` hold stable and `col_read` stays 0.
- Reset mid-drain: pending `wb_valid` beat is discarded; no `done`.

## Configuration
- `RESULT_DRAIN_PARITY_EN` defined:
  - Adds output `wb_parity` (1 bit): even parity over `{wb_addr, wb_data}`, registered alongside them.
  - Reset value 0.
- Undefined: the port does not exist; all other behaviour identical.

## Test plan
- Reset: assert `rstn=0` mid-cycle with all inputs toggling → every output 0 immediately; after release, state IDLE and no `col_read`.
- Single column: `start`, only `col_rvalid[0]=1` with `col_r` = 0x10..0x17 over 8 pops, `wb_ready=1` → `col_read[0]` pulses 8 consecutive cycles, `wb_addr` 0x00..0x07, data matches; other columns then supply their 8 → `done` pulses once after beat 64.
- Round-robin: all `col_rvalid=1` from start → grant order 0,1,…,7,0,…; `wb_addr` = 0x00,0x08,0x10,…,0x38,0x01,…; one result per cycle; 64 beats then `done`.
- Back-pressure: hold `wb_ready=0` for 5 cycles with `wb_valid=1` → `wb_data`/`wb_addr` stable, `col_read` all 0; on release, next pop in the same cycle as acceptance.
- Over-delivery: column 3 keeps `col_rvalid=1` after 8 pops → never granted again; `row_cnt[3]` stays 8; `done` still only at 64.
- Parity (macro on): `wb_addr=0x05`, `wb_data=0x1` → `wb_parity=1`.
